// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the next-PC sequencer.
// Holds the FSM state enum, NextPCSrc encodings and default vectors.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JALR = 2'b10;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational next-PC target and misalign flag.
// In: PCOut, Imm, RS1, NextPCSrc. Out: target, misaligned.
module pc_target_calc
  import pc_pkg::*;
(
  input  logic        [31:0] PCOut,
  input  logic signed [31:0] Imm,
  input  logic        [31:0] RS1,
  input  logic        [1:0]  NextPCSrc,
  output logic        [31:0] target,
  output logic               misaligned
);

  logic [31:0] imm_u;
  logic [31:0] jalr_sum;

  assign imm_u    = Imm;
  assign jalr_sum = RS1 + imm_u;

  // Reserved encoding 11 falls into the sequential default.
  always_comb begin
    target = PCOut + 32'd4;
    unique case (1'b1)
      (NextPCSrc == PCSRC_BR):   target = PCOut + imm_u;
      (NextPCSrc == PCSRC_JALR): target = jalr_sum & ~32'h1;
      default:                   target = PCOut + 32'd4;
    endcase
  end

  assign misaligned = |target[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: drives PCIn/PCWr; BOOT/RUN/HALT FSM, trap capture.
// Optional RetireCnt output when RETIRE_CNT_EN is defined.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCOut,
  input  logic [1:0]  NextPCSrc,
  input  logic [31:0] Imm,
  input  logic [31:0] RS1,
  input  logic        Stall,
  input  logic        Halt,
  output logic [31:0] PCIn,
  output logic        PCWr,
  output logic        Halted,
  output logic        MisalignErr,
  output logic [31:0] TrapPC
`ifdef RETIRE_CNT_EN
  ,
  output logic [31:0] RetireCnt
`endif
);

  pc_state_e   state_q;
  pc_state_e   state_d;
  logic [31:0] target;
  logic        misaligned;
  logic        trap;

  pc_target_calc u_calc (
    .PCOut     (PCOut),
    .Imm       (Imm),
    .RS1       (RS1),
    .NextPCSrc (NextPCSrc),
    .target    (target),
    .misaligned(misaligned)
  );

  always_comb begin
    state_d = state_q;
    PCIn    = RESET_VECTOR;
    PCWr    = 1'b0;
    trap    = 1'b0;
    if (rst) begin
      state_d = ST_BOOT;
    end else begin
      case (state_q)
        ST_BOOT: begin
          PCWr    = 1'b1;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          PCIn = target;
          if (Halt) begin
            state_d = ST_HALT;
          end else if (!Stall) begin
            PCWr = 1'b1;
            if (misaligned) begin
              PCIn = TRAP_VECTOR;
              trap = 1'b1;
            end
          end
        end
        ST_HALT: begin
          PCIn = PCOut;
        end
        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      Halted      <= 1'b0;
      MisalignErr <= 1'b0;
      TrapPC      <= 32'h0;
    end else begin
      state_q <= state_d;
      Halted  <= (state_d == ST_HALT);
      if (trap) begin
        MisalignErr <= 1'b1;
        // Only the first trap is recorded.
        if (!MisalignErr) TrapPC <= PCOut;
      end
    end
  end

`ifdef RETIRE_CNT_EN
  logic retire;

  assign retire = (state_q == ST_RUN) && PCWr && !trap;

  always_ff @(posedge clk) begin
    if (rst) RetireCnt <= 32'h0;
    else if (retire) RetireCnt <= RetireCnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random checks of pc_sequencer
// against a behavioural PC model; bench plays the PC register.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCOut;
  logic [1:0]  NextPCSrc;
  logic [31:0] Imm;
  logic [31:0] RS1;
  logic        Stall;
  logic        Halt;
  logic [31:0] PCIn;
  logic        PCWr;
  logic        Halted;
  logic        MisalignErr;
  logic [31:0] TrapPC;
`ifdef RETIRE_CNT_EN
  logic [31:0] RetireCnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [31:0] pc_m = 32'h0;
  bit          known = 0;
  bit          boot_m = 0;
  bit          halt_m = 0;
  bit          err_m = 0;
  logic [31:0] trap_m = 32'h0;
  logic [31:0] cnt_m = 32'h0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .PCOut      (PCOut),
    .NextPCSrc  (NextPCSrc),
    .Imm        (Imm),
    .RS1        (RS1),
    .Stall      (Stall),
    .Halt       (Halt),
    .PCIn       (PCIn),
    .PCWr       (PCWr),
    .Halted     (Halted),
    .MisalignErr(MisalignErr),
    .TrapPC     (TrapPC)
`ifdef RETIRE_CNT_EN
    ,
    .RetireCnt  (RetireCnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check against model, advance model.
  task automatic step(input bit r, input logic [1:0] src,
                      input logic [31:0] imm, input logic [31:0] rs1,
                      input bit st, input bit hl);
    logic [31:0] tgt;
    bit          ew;
    logic [31:0] ein;
    bit          chk_in;
    bit          is_trap;
    @(negedge clk);
    rst = r;
    NextPCSrc = src;
    Imm = imm;
    RS1 = rs1;
    Stall = st;
    Halt = hl;
    PCOut = pc_m;
    #1;
    if (src == 2'b01) tgt = pc_m + imm;
    else if (src == 2'b10) tgt = (rs1 + imm) & 32'hFFFF_FFFE;
    else tgt = pc_m + 32'd4;
    ew = 0; ein = RV; chk_in = 1; is_trap = 0;
    if (r) begin
      ew = 0; ein = RV;
    end else if (boot_m) begin
      ew = 1; ein = RV;
    end else if (halt_m || hl) begin
      ew = 0; chk_in = 0;
    end else if (st) begin
      ew = 0; ein = tgt;
    end else if (tgt % 4 != 0) begin
      ew = 1; ein = TV; is_trap = 1;
    end else begin
      ew = 1; ein = tgt;
    end
    chk("PCWr", {31'b0, PCWr}, {31'b0, ew});
    if (chk_in) chk("PCIn", PCIn, ein);
    if (known) begin
      chk("Halted", {31'b0, Halted}, {31'b0, halt_m});
      chk("MisalignErr", {31'b0, MisalignErr}, {31'b0, err_m});
      chk("TrapPC", TrapPC, trap_m);
`ifdef RETIRE_CNT_EN
      chk("RetireCnt", RetireCnt, cnt_m);
`endif
    end
    @(posedge clk);
    if (r) begin
      known = 1; boot_m = 1; halt_m = 0; err_m = 0;
      trap_m = 0; cnt_m = 0;
    end else if (boot_m) begin
      boot_m = 0; pc_m = RV;
    end else if (!halt_m) begin
      if (hl) halt_m = 1;
      else if (!st) begin
        if (is_trap) begin
          if (!err_m) trap_m = pc_m;
          err_m = 1;
          pc_m = TV;
        end else begin
          pc_m = tgt;
          cnt_m = cnt_m + 1;
        end
      end
    end
  endtask

  task automatic seq1();
    step(0, 2'b00, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; NextPCSrc = 0; Imm = 0; RS1 = 0; Stall = 0; Halt = 0;
    PCOut = 0;
    // boot
    pc_m = 32'h0000_0040;
    step(1, 2'b00, 0, 0, 0, 0);
    step(1, 2'b00, 0, 0, 0, 0);
    seq1();
    seq1();
    chk("boot_pc", pc_m, 32'h0000_0004);
    // branch, wrap
    pc_m = 32'h0000_0200;
    step(0, 2'b01, 32'hFFFF_FFF8, 0, 0, 0);
    chk("branch_pc", pc_m, 32'h0000_01F8);
    pc_m = 32'hFFFF_FFFC;
    seq1();
    chk("wrap_pc", pc_m, 32'h0000_0000);
    pc_m = 32'h0000_0010;
    step(0, 2'b11, 0, 0, 0, 0);
    // jalr
    step(0, 2'b10, 32'h3, 32'h0000_1001, 0, 0);
    chk("jalr_pc", pc_m, 32'h0000_1004);
    step(0, 2'b10, 32'h0, 32'h0000_1002, 0, 0);
    seq1();
    chk("trap_err", {31'b0, MisalignErr}, 32'h1);
    chk("trap_pc", TrapPC, 32'h0000_1004);
    // second trap keeps first capture
    step(0, 2'b01, 32'h2, 0, 0, 0);
    seq1();
    chk("trap_keep", TrapPC, 32'h0000_1004);
    // stall then halt
    pc_m = 32'h0000_000C;
    repeat (3) step(0, 2'b00, 0, 0, 1, 0);
    chk("stall_pc", pc_m, 32'h0000_000C);
    step(0, 2'b00, 0, 0, 1, 1);
    repeat (5) step(0, 2'b01, 32'h40, 0, 0, 0);
    chk("halt_flag", {31'b0, Halted}, 32'h1);
    // reset from halt
    step(1, 2'b00, 0, 0, 0, 0);
    seq1();
    chk("rst_halt_pc", pc_m, RV);
`ifdef RETIRE_CNT_EN
    step(1, 2'b00, 0, 0, 0, 0);
    seq1();
    repeat (4) seq1();
    step(0, 2'b00, 0, 0, 1, 0);
    step(0, 2'b01, 32'h1, 0, 0, 0);
    @(negedge clk);
    chk("retire_4", RetireCnt, 32'd4);
`endif
    // random
    step(1, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      bit          r;
      bit          st;
      bit          hl;
      logic [1:0]  src;
      logic [31:0] imm;
      logic [31:0] rs1;
      r   = ($urandom_range(0, 99) < 2);
      st  = ($urandom_range(0, 99) < 20);
      hl  = ($urandom_range(0, 99) < 3);
      src = 2'($urandom_range(0, 3));
      imm = $urandom;
      if ($urandom_range(0, 9) < 8) imm[1:0] = 2'b00;
      rs1 = $urandom;
      if ($urandom_range(0, 9) < 8) rs1[1:0] = 2'b00;
      if ($urandom_range(0, 19) == 0) pc_m = 32'hFFFF_FFFC;
      step(r, src, imm, rs1, st, hl);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
